// File: rtl/alu_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_input_loader
// Purpose  : Loads ALU operands A and B and a 2-bit opcode from 16 slide
//            switches. Two bouncing pushbuttons (enter, clear) are
//            synchronized and debounced. A small sequencer steps through the
//            operand halves, and the completed set is committed to the
//            outputs in a single atomic load.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      single rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   switches   in   16     operand / opcode entry value (quasi-static)
//   btn_enter  in   1      raw pushbutton, active-high, bouncing
//   btn_clear  in   1      raw pushbutton, active-high, bouncing
//   A          out  WIDTH  committed operand A
//   B          out  WIDTH  committed operand B
//   OpCode     out  2      committed ALU opcode
//   valid      out  1      high while the committed set is shown (SHOW)
//   step       out  3      current sequencer state code, for the LEDs
// ============================================================================
module alu_input_loader #(
    parameter int WIDTH           = 32,        // 16 or 32
    parameter int DEBOUNCE_CYCLES = 1_000_000  // minimum 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      switches,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       OpCode,
    output logic             valid,
    output logic [2:0]       step
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               HAS_HI   = (WIDTH == 32);

    // ------------------------------------------------------------------
    // Button conditioning. Index 0 = enter, index 1 = clear.
    // ------------------------------------------------------------------
    logic [1:0]       raw;
    logic [1:0]       sync_1;
    logic [1:0]       sync_2;
    logic [1:0]       level;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {btn_clear, btn_enter};

    // The counter measures how long the synchronized value has disagreed
    // with the debounced level; any agreeing cycle restarts it. The level
    // flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, and a
    // one-cycle press pulse is registered only when it flips to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
            level  <= '0;
            press  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= ~level[i];
                    press[i] <= ~level[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic enter_evt;
    logic clear_evt;

    assign enter_evt = press[0];
    assign clear_evt = press[1];

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        A_LO = 3'd0,
        A_HI = 3'd1,
        B_LO = 3'd2,
        B_HI = 3'd3,
        OP   = 3'd4,
        SHOW = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] a_lo;
    logic [15:0] a_hi;
    logic [15:0] b_lo;
    logic [15:0] b_hi;
    logic [31:0] a_full;
    logic [31:0] b_full;

    assign a_full = {a_hi, a_lo};
    assign b_full = {b_hi, b_lo};
    assign step   = state;

    // In the 16-bit build the HI states are skipped entirely.
    function automatic state_t next_state(input state_t s);
        case (s)
            A_LO:    next_state = HAS_HI ? A_HI : B_LO;
            A_HI:    next_state = B_LO;
            B_LO:    next_state = HAS_HI ? B_HI : OP;
            B_HI:    next_state = OP;
            OP:      next_state = SHOW;
            default: next_state = A_LO;
        endcase
    endfunction

    // Clear is tested first so that it wins over a simultaneous enter.
    // The opcode is captured in OP, which is also the commit edge, so it
    // goes straight to OpCode alongside the staged operands; no separate
    // staging register is needed to keep the commit atomic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= A_LO;
            a_lo   <= '0;
            a_hi   <= '0;
            b_lo   <= '0;
            b_hi   <= '0;
            A      <= '0;
            B      <= '0;
            OpCode <= '0;
            valid  <= 1'b0;
        end else if (clear_evt) begin
            state <= A_LO;
            a_lo  <= '0;
            a_hi  <= '0;
            b_lo  <= '0;
            b_hi  <= '0;
            valid <= 1'b0;
        end else if (enter_evt) begin
            case (state)
                A_LO: a_lo <= switches;
                A_HI: a_hi <= switches;
                B_LO: b_lo <= switches;
                B_HI: b_hi <= switches;
                OP: begin
                    A      <= a_full[WIDTH-1:0];
                    B      <= b_full[WIDTH-1:0];
                    OpCode <= switches[1:0];
                end
                default: ;
            endcase
            state <= next_state(state);
            valid <= (next_state(state) == SHOW);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_input_loader
// Purpose  : Self-checking bench for alu_input_loader. Drives a 32-bit and a
//            16-bit instance (DEBOUNCE_CYCLES=4) with directed button and
//            switch sequences; a window-based model of debounce plus a plain
//            state-sequence model predicts every output on every cycle, and
//            literal expectations pin the key results.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_input_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] switches = '0;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_enter16 = 1'b0;
    logic        btn_clear16 = 1'b0;

    logic [31:0] a32, b32;
    logic [1:0]  op32;
    logic        valid32;
    logic [2:0]  step32;
    logic [15:0] a16, b16;
    logic [1:0]  op16;
    logic        valid16;
    logic [2:0]  step16;

    always #5 clk = ~clk;

    alu_input_loader #(.WIDTH(32), .DEBOUNCE_CYCLES(D)) dut32 (
        .clk(clk), .reset(reset), .switches(switches),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .A(a32), .B(b32), .OpCode(op32), .valid(valid32), .step(step32)
    );

    alu_input_loader #(.WIDTH(16), .DEBOUNCE_CYCLES(D)) dut16 (
        .clk(clk), .reset(reset), .switches(switches),
        .btn_enter(btn_enter16), .btn_clear(btn_clear16),
        .A(a16), .B(b16), .OpCode(op16), .valid(valid16), .step(step16)
    );

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = 32-bit instance, 1 = 16-bit instance.
    // he/hc hold raw button samples, bit j = sample taken j edges ago.
    bit [15:0] he [2];
    bit [15:0] hc [2];
    bit        lvl_e [2];
    bit        lvl_c [2];
    bit        pend_e [2];
    bit        pend_c [2];
    int        m_state [2];
    bit [15:0] s_alo [2];
    bit [15:0] s_ahi [2];
    bit [15:0] s_blo [2];
    bit [15:0] s_bhi [2];
    bit [31:0] m_a [2];
    bit [31:0] m_b [2];
    bit [1:0]  m_op [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // True when the synchronized samples seen by the last D debounce
    // evaluations all disagree with the current debounced level.
    function automatic bit settles(input bit [15:0] h, input bit lvl);
        for (int j = 2; j <= D + 1; j++)
            if (h[j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset(input int i);
        he[i] = '0; hc[i] = '0;
        lvl_e[i] = 0; lvl_c[i] = 0; pend_e[i] = 0; pend_c[i] = 0;
        m_state[i] = 0;
        s_alo[i] = '0; s_ahi[i] = '0; s_blo[i] = '0; s_bhi[i] = '0;
        m_a[i] = '0; m_b[i] = '0; m_op[i] = '0;
    endtask

    task automatic model_edge(input int i, input bit rst_n, input bit e, input bit c,
                              input bit [15:0] sw, input bit wide);
        bit ev_e, ev_c;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        he[i] = {he[i][14:0], e};
        hc[i] = {hc[i][14:0], c};
        ev_e = pend_e[i];
        ev_c = pend_c[i];
        pend_e[i] = 0;
        pend_c[i] = 0;
        if (settles(he[i], lvl_e[i])) begin
            lvl_e[i] = !lvl_e[i];
            pend_e[i] = lvl_e[i];
        end
        if (settles(hc[i], lvl_c[i])) begin
            lvl_c[i] = !lvl_c[i];
            pend_c[i] = lvl_c[i];
        end
        if (ev_c) begin
            s_alo[i] = '0; s_ahi[i] = '0; s_blo[i] = '0; s_bhi[i] = '0;
            m_state[i] = 0;
        end else if (ev_e) begin
            case (m_state[i])
                0: s_alo[i] = sw;
                1: s_ahi[i] = sw;
                2: s_blo[i] = sw;
                3: s_bhi[i] = sw;
                4: begin
                    m_a[i]  = wide ? {s_ahi[i], s_alo[i]} : {16'h0, s_alo[i]};
                    m_b[i]  = wide ? {s_bhi[i], s_blo[i]} : {16'h0, s_blo[i]};
                    m_op[i] = sw[1:0];
                end
                default: ;
            endcase
            if (m_state[i] == 5)      m_state[i] = 0;
            else if (m_state[i] == 4) m_state[i] = 5;
            else                      m_state[i] = m_state[i] + (wide ? 1 : 2);
        end
    endtask

    task automatic compare_all();
        chk("A32", a32, m_a[0]);
        chk("B32", b32, m_b[0]);
        chk("op32", {30'd0, op32}, {30'd0, m_op[0]});
        chk("valid32", {31'd0, valid32}, (m_state[0] == 5) ? 32'd1 : 32'd0);
        chk("step32", {29'd0, step32}, m_state[0]);
        chk("A16", {16'd0, a16}, m_a[1]);
        chk("B16", {16'd0, b16}, m_b[1]);
        chk("op16", {30'd0, op16}, {30'd0, m_op[1]});
        chk("valid16", {31'd0, valid16}, (m_state[1] == 5) ? 32'd1 : 32'd0);
        chk("step16", {29'd0, step16}, m_state[1]);
        chk("step16_no_hi", (step16 == 3'd1 || step16 == 3'd3) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Inputs only change after tick() returns, so the values read here are
    // the ones the DUT sampled on this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(0, reset, btn_enter, btn_clear, switches, 1'b1);
        model_edge(1, reset, btn_enter16, btn_clear16, switches, 1'b0);
        compare_all();
    endtask

    // Clean press: hold long enough to be accepted, release long enough for
    // the debounced level to fall again.
    task automatic press(input int i, input bit ent, input bit clr, input logic [15:0] sw);
        switches = sw;
        if (i == 0) begin btn_enter = ent; btn_clear = clr; end
        else        begin btn_enter16 = ent; btn_clear16 = clr; end
        repeat (D + 3) tick();
        btn_enter = 0; btn_clear = 0; btn_enter16 = 0; btn_clear16 = 0;
        repeat (D + 4) tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);

        // Reset state
        repeat (3) tick();
        chk("rst_step", {29'd0, step32}, 32'd0);
        chk("rst_A", a32, 32'd0);
        chk("rst_valid", {31'd0, valid32}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Full load
        press(0, 1, 0, 16'h0011);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'h0011);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'h0000);
        chk("full_A", a32, 32'h0000_0011);
        chk("full_B", b32, 32'h0000_0011);
        chk("full_op", {30'd0, op32}, 32'd0);
        chk("full_valid", {31'd0, valid32}, 32'd1);
        chk("full_step", {29'd0, step32}, 32'd5);

        // Leave SHOW, then upper-half assembly
        press(0, 1, 0, 16'h0000);
        chk("leave_valid", {31'd0, valid32}, 32'd0);
        press(0, 1, 0, 16'h5678);
        press(0, 1, 0, 16'h1234);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'hFFFF);
        press(0, 1, 0, 16'h0001);
        chk("hi_A", a32, 32'h1234_5678);
        chk("hi_B", b32, 32'hFFFF_0000);
        chk("hi_op", {30'd0, op32}, 32'd1);

        // Bounce rejection, then one clean press from SHOW
        for (int r = 0; r < 5; r++) begin
            btn_enter = 1; repeat (3) tick();
            btn_enter = 0; tick();
        end
        repeat (4) tick();
        chk("bounce_step", {29'd0, step32}, 32'd5);
        btn_enter = 1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            chk("bounce_edge", {29'd0, step32}, (j >= 7) ? 32'd0 : 32'd5);
        end
        btn_enter = 0;
        repeat (D + 4) tick();

        // Clear mid-load
        press(0, 1, 0, 16'hAAAA);
        press(0, 1, 0, 16'hBBBB);
        press(0, 1, 0, 16'hCCCC);
        chk("pre_clear_step", {29'd0, step32}, 32'd3);
        press(0, 0, 1, 16'h0000);
        chk("clear_step", {29'd0, step32}, 32'd0);
        chk("clear_valid", {31'd0, valid32}, 32'd0);
        chk("clear_A_held", a32, 32'h1234_5678);
        chk("clear_B_held", b32, 32'hFFFF_0000);
        chk("clear_op_held", {30'd0, op32}, 32'd1);
        press(0, 1, 0, 16'h0007);
        press(0, 1, 1, 16'h0009);
        chk("both_step", {29'd0, step32}, 32'd0);

        // Reset mid-operation, asserted between clock edges
        press(0, 1, 0, 16'h0001);
        press(0, 1, 0, 16'h0002);
        press(0, 1, 0, 16'h0003);
        press(0, 1, 0, 16'h0004);
        chk("pre_rst_step", {29'd0, step32}, 32'd4);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) model_reset(i);
        compare_all();
        chk("async_A", a32, 32'd0);
        chk("async_step", {29'd0, step32}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rel_step", {29'd0, step32}, 32'd0);
        press(0, 1, 0, 16'h0F0F);
        press(0, 1, 0, 16'h00F0);
        press(0, 1, 0, 16'h0003);
        press(0, 1, 0, 16'h0000);
        press(0, 1, 0, 16'h0003);
        chk("reload_A", a32, 32'h00F0_0F0F);
        chk("reload_B", b32, 32'h0000_0003);
        chk("reload_op", {30'd0, op32}, 32'd3);
        chk("reload_step", {29'd0, step32}, 32'd5);

        // 16-bit variant
        press(1, 1, 0, 16'hABCD);
        press(1, 1, 0, 16'h0001);
        press(1, 1, 0, 16'h0002);
        chk("w16_A", {16'd0, a16}, 32'h0000_ABCD);
        chk("w16_B", {16'd0, b16}, 32'h0000_0001);
        chk("w16_op", {30'd0, op16}, 32'd2);
        chk("w16_valid", {31'd0, valid16}, 32'd1);
        chk("w16_step", {29'd0, step16}, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
